pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit for the MIPS fetch stage. Holds the
//  fetch PC, advances it by STEP on each accepted fetch, and applies
//  branch/jump redirects, stalls and (optionally) exception/ERET vectoring.
//  Sits between the hazard/branch logic and the instruction memory, using a
//  valid/ready fetch handshake.
// PARAMETERS
//  WIDTH      32            PC width in bits
//  RESET_VEC  32'h00000000  PC value loaded on reset
//  EXC_VEC    32'h80000180  exception entry address (PC_EXC_EN only)
//  STEP       4             byte increment per accepted fetch (power of 2)
// PORTS
//  clk          in   1      clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  stall        in   1      hold PC; fetch_valid stays as is, no advance
//  redirect     in   1      load redirect_pc next edge (branch/jump taken)
//  redirect_pc  in   WIDTH  redirect target
//  fetch_ready  in   1      imem accepts the current fetch this cycle
//  fetch_valid  out  1      pc is a valid fetch request
//  pc           out  WIDTH  current fetch PC
//  pc_plus      out  WIDTH  pc + STEP, combinational, modulo 2^WIDTH
//  misalign     out  1      one-cycle pulse: last loaded target was misaligned
//  exc          in   1      exception request (PC_EXC_EN only)
//  eret         in   1      return from exception (PC_EXC_EN only)
//  epc          out  WIDTH  saved exception PC (PC_EXC_EN only)
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-fetch):
//    pc=RESET_VEC, fetch_valid=0, misalign=0, epc=0, state=BOOT.
//  - FSM: BOOT -> RUN on the first clk edge after reset deasserts.
//    fetch_valid=0 in BOOT and 1 in RUN. RUN is held until reset.
//  - Next-PC priority, evaluated at each edge in RUN (highest first):
//    1 exc (EN)    : pc<=EXC_VEC, epc<=pc
//    2 eret (EN)   : pc<=epc
//    3 redirect    : pc<=redirect_pc with low log2(STEP) bits cleared
//    4 stall       : pc holds
//    5 fetch_valid & fetch_ready : pc<=pc_plus
//    6 otherwise   : pc holds (imem back-pressure)
//  - Redirect/exc/eret override stall and back-pressure, with 1-cycle
//    latency: the new pc is visible the cycle after the request.
//  - A redirect or exc/eret in BOOT is ignored.
//  - misalign=1 for exactly one cycle after a redirect_pc (or epc on ERET)
//    whose low log2(STEP) bits were nonzero; otherwise 0.
//  - Wrap-around: pc_plus from all-ones region wraps modulo 2^WIDTH; no flag.
//  - pc is a registered output; it never changes between edges except on reset.
// CONFIGURATION
//  PC_EXC_EN defined:
//    exc/eret are active and epc is a register (reset 0). epc updates only
//    on exc. exc and eret in the same cycle: exc wins and epc<=pc.
//  PC_EXC_EN undefined:
//    exc/eret are ignored, epc is tied to 0, and priorities 1-2 do not exist.
//  The port list is identical in both builds.
// TESTING
//  1 Reset (RESET_VEC=0), release, fetch_ready=1 -> BOOT 1 cycle, then pc
//    0,4,8,C on consecutive cycles with fetch_valid=1.
//  2 pc=0x10, fetch_ready=0 for 3 cycles -> pc holds 0x10; ready=1 -> 0x14.
//  3 stall=1 and redirect=1, redirect_pc=0x200 in the same cycle ->
//    next pc=0x200; stall=1 only -> pc holds.
//  4 redirect_pc=0x103 -> pc=0x100, misalign high for 1 cycle.
//  5 pc=0xFFFFFFFC, fetch_ready=1 -> pc=0x0, no error.
//  6 (EN) pc=0x40, exc=1 and eret=1 -> pc=0x80000180, epc=0x40;
//    eret=1 -> pc=0x40. Reset asserted mid-sequence -> pc=0, epc=0,
//    fetch_valid=0 immediately.

Source files
------------

// File: rtl/pc_unit_if.sv
// Fetch-side bundle for pc_unit: redirect/stall control in, fetch request and PC state out.
// exc/eret/epc are present in every build; they only act when PC_EXC_EN is defined.
interface pc_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             stall;
    logic             redirect;
    logic [WIDTH-1:0] redirect_pc;
    logic             fetch_ready;
    logic             fetch_valid;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus;
    logic             misalign;
    logic             exc;
    logic             eret;
    logic [WIDTH-1:0] epc;

    modport master (
        input  stall, redirect, redirect_pc, fetch_ready, exc, eret,
        output fetch_valid, pc, pc_plus, misalign, epc
    );

    modport slave (
        output stall, redirect, redirect_pc, fetch_ready, exc, eret,
        input  fetch_valid, pc, pc_plus, misalign, epc
    );
endinterface

// File: rtl/pc_unit.sv
// MIPS fetch-stage program counter: BOOT/RUN FSM, prioritised next-PC selection, valid/ready fetch.
// Define PC_EXC_EN to enable exception entry (exc), ERET return and the epc register.
module pc_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC   = 32'h80000180,
    parameter int unsigned      STEP      = 4
) (
    input  logic       clk,
    input  logic       reset,
    pc_unit_if.master  bus
);
    typedef enum logic {BOOT, RUN} state_t;

    // Low address bits that must be zero for an aligned fetch target.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);

    state_t           state;
    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] epc_q;
    logic             fetch_valid_q;
    logic             misalign_q;
    logic             exc_take;
    logic             eret_take;
    logic [WIDTH-1:0] redirect_aligned;
    logic [WIDTH-1:0] pc_next_seq;

`ifdef PC_EXC_EN
    assign exc_take  = bus.exc;
    assign eret_take = bus.eret & ~bus.exc;
    assign bus.epc   = epc_q;
`else
    logic unused_exc_inputs;
    assign unused_exc_inputs = bus.exc | bus.eret;
    assign exc_take  = 1'b0;
    assign eret_take = 1'b0;
    assign bus.epc   = '0;
`endif

    assign redirect_aligned = bus.redirect_pc & ~ALIGN_MASK;
    assign pc_next_seq      = pc_q + WIDTH'(STEP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= BOOT;
            pc_q          <= RESET_VEC;
            epc_q         <= '0;
            fetch_valid_q <= 1'b0;
            misalign_q    <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state)
                BOOT: begin
                    state         <= RUN;
                    fetch_valid_q <= 1'b1;
                end
                RUN: begin
                    if (exc_take) begin
                        epc_q <= pc_q;
                        pc_q  <= EXC_VEC;
                    end else if (eret_take) begin
                        pc_q       <= epc_q;
                        misalign_q <= |(epc_q & ALIGN_MASK);
                    end else if (bus.redirect) begin
                        pc_q       <= redirect_aligned;
                        misalign_q <= |(bus.redirect_pc & ALIGN_MASK);
                    end else if (!bus.stall && fetch_valid_q && bus.fetch_ready) begin
                        pc_q <= pc_next_seq;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    assign bus.pc          = pc_q;
    assign bus.pc_plus     = pc_next_seq;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.misalign    = misalign_q;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus random control traffic vs a reference model.
// Exception/ERET scenarios run only when PC_EXC_EN is defined.
module tb_pc_unit;
    localparam int unsigned WIDTH     = 32;
    localparam logic [31:0] RESET_VEC = 32'h0;
    localparam logic [31:0] EXC_VEC   = 32'h80000180;
    localparam int unsigned STEP      = 4;
`ifdef PC_EXC_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pc_unit_if #(.WIDTH(WIDTH)) bus ();

    pc_unit #(
        .WIDTH(WIDTH), .RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC), .STEP(STEP)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: what the PC unit should show after the last edge.
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    bit          m_run;
    bit          m_mis;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pc", bus.pc, m_pc);
        chk("fetch_valid", {31'b0, bus.fetch_valid}, {31'b0, m_run});
        chk("pc_plus", bus.pc_plus, 32'((longint'(m_pc) + STEP) % 64'h1_0000_0000));
        chk("misalign", {31'b0, bus.misalign}, {31'b0, m_mis});
        chk("epc", bus.epc, EN ? m_epc : 32'h0);
    endtask

    task automatic model_reset();
        m_pc  = RESET_VEC;
        m_epc = 32'h0;
        m_run = 1'b0;
        m_mis = 1'b0;
    endtask

    // One rising edge worth of behaviour, from the currently driven inputs.
    task automatic model_edge();
        if (!m_run) begin
            m_run = 1'b1;
            m_mis = 1'b0;
        end else begin
            m_mis = 1'b0;
            if (EN && bus.exc) begin
                m_epc = m_pc;
                m_pc  = EXC_VEC;
            end else if (EN && bus.eret) begin
                m_mis = (m_epc % STEP) != 0;
                m_pc  = m_epc;
            end else if (bus.redirect) begin
                m_mis = (bus.redirect_pc % STEP) != 0;
                m_pc  = bus.redirect_pc - (bus.redirect_pc % STEP);
            end else if (!bus.stall && bus.fetch_ready) begin
                m_pc = 32'((longint'(m_pc) + STEP) % 64'h1_0000_0000);
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input bit st, input bit rd, input logic [31:0] rpc,
                         input bit rdy, input bit ex, input bit er);
        bus.stall       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.fetch_ready = rdy;
        bus.exc         = ex;
        bus.eret        = er;
    endtask

    // Asserts reset mid-cycle, checks its immediate effect, releases just after an edge.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 32'h0, 1, 0, 0);
        model_reset();
        #12;
        check_all();
        chk("reset_pc", bus.pc, 32'h0);
        chk("reset_fv", {31'b0, bus.fetch_valid}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Boot cycle then sequential fetch 0,4,8,C,10
        step();
        chk("boot_pc", bus.pc, 32'h0);
        chk("boot_fv", {31'b0, bus.fetch_valid}, 32'h1);
        step(); chk("seq_4", bus.pc, 32'h4);
        step(); chk("seq_8", bus.pc, 32'h8);
        step(); chk("seq_c", bus.pc, 32'hC);
        step(); chk("seq_10", bus.pc, 32'h10);

        // Back-pressure holds, then resumes
        drive(0, 0, 32'h0, 0, 0, 0);
        repeat (3) step();
        chk("bp_hold", bus.pc, 32'h10);
        drive(0, 0, 32'h0, 1, 0, 0);
        step(); chk("bp_resume", bus.pc, 32'h14);

        // Redirect overrides stall; stall alone holds
        drive(1, 1, 32'h200, 1, 0, 0);
        step(); chk("redir_stall", bus.pc, 32'h200);
        drive(1, 0, 32'h0, 1, 0, 0);
        step(); chk("stall_hold", bus.pc, 32'h200);

        // Misaligned redirect: aligned target, one-cycle misalign pulse
        drive(0, 1, 32'h103, 1, 0, 0);
        step();
        chk("mis_pc", bus.pc, 32'h100);
        chk("mis_pulse", {31'b0, bus.misalign}, 32'h1);
        drive(0, 0, 32'h0, 1, 0, 0);
        step(); chk("mis_clear", {31'b0, bus.misalign}, 32'h0);

        // Wrap-around at top of address space
        drive(0, 1, 32'hFFFFFFFC, 0, 0, 0);
        step(); chk("wrap_top", bus.pc, 32'hFFFFFFFC);
        chk("wrap_plus", bus.pc_plus, 32'h0);
        drive(0, 0, 32'h0, 1, 0, 0);
        step(); chk("wrap_zero", bus.pc, 32'h0);

`ifdef PC_EXC_EN
        // Exception wins over simultaneous ERET, then ERET returns
        drive(0, 1, 32'h40, 1, 0, 0);
        step(); chk("exc_setup", bus.pc, 32'h40);
        drive(0, 0, 32'h0, 1, 1, 1);
        step();
        chk("exc_pc", bus.pc, 32'h80000180);
        chk("exc_epc", bus.epc, 32'h40);
        drive(1, 0, 32'h0, 0, 0, 1);
        step(); chk("eret_pc", bus.pc, 32'h40);
        drive(0, 0, 32'h0, 1, 1, 0);
        step();
        do_reset();
        chk("rst_epc", bus.epc, 32'h0);
        chk("rst_pc", bus.pc, 32'h0);
        step();
`else
        // Without exception support exc/eret must do nothing
        drive(0, 0, 32'h0, 0, 1, 1);
        step();
        chk("noexc_pc", bus.pc, 32'h0);
        chk("noexc_epc", bus.epc, 32'h0);
`endif

        // Redirect in BOOT is ignored
        do_reset();
        drive(0, 1, 32'h500, 1, 1, 0);
        step(); chk("boot_ignore", bus.pc, 32'h0);

        // Random control traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom,
                  $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 11) == 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            else step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
